// File: rtl/slow_mem_pkg.sv
// Shared types and default geometry for the line-granular slow memory controller.
package slow_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RECOVER
  } state_e;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_e;

  localparam int DEF_ADDR_W  = 28;
  localparam int DEF_LINE_W  = 128;
  localparam int DEF_DEPTH   = 256;
  localparam int DEF_LATENCY = 5;
  localparam int DEF_CNT_W   = 16;

endpackage

// File: rtl/slow_mem_array.sv
// DEPTH x LINE_W single-port line store: clocked write, combinational read.
// Zero latency on the read path; no backpressure, the controller owns sequencing.
module slow_mem_array #(
  parameter int LINE_W = 128,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata
);

  logic [LINE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/slow_mem_ctrl.sv
// One-at-a-time line read/write controller; mem_ready pulses LATENCY edges after sampling.
// No queuing: requests are ignored outside IDLE, so the requester holds the level until mem_ready.
module slow_mem_ctrl
  import slow_mem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LINE_W  = DEF_LINE_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int LATENCY = DEF_LATENCY,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0] mem_wdata,
  output logic [LINE_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              oob_err,
  output logic              proto_err,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic              oob_q, oob_d;
  logic              proto_q, proto_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;

  logic              req;
  logic              access;
  logic              addr_oob;
  logic              arr_we;
  logic [LINE_W-1:0] arr_rdata;

  assign req      = mem_read | mem_write;
  assign addr_oob = (addr_q >= ADDR_W'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= OP_RD;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      oob_q    <= 1'b0;
      proto_q  <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      oob_q    <= oob_d;
      proto_q  <= proto_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = BUSY;
      BUSY:    if (cnt_q == '0) state_d = RECOVER;
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    oob_d    = oob_q;
    proto_d  = proto_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    access   = (state_q == BUSY) && (cnt_q == '0);
    arr_we   = 1'b0;
    mem_ready = (state_q == RECOVER);

    if (state_q == IDLE && req) begin
      // A conflicting request resolves to a write so the data is never silently lost.
      op_d    = mem_write ? OP_WR : OP_RD;
      addr_d  = mem_addr;
      wdata_d = mem_wdata;
      cnt_d   = LAT_W'(LATENCY - 1);
      if (mem_read && mem_write) proto_d = 1'b1;
    end

    if (state_q == BUSY && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end

    if (access) begin
      if (addr_oob) oob_d = 1'b1;
      if (op_q == OP_RD) begin
        rdata_d  = addr_oob ? '0 : arr_rdata;
        rd_cnt_d = (rd_cnt_q == '1) ? rd_cnt_q : rd_cnt_q + 1'b1;
      end else begin
        arr_we   = !addr_oob && !rst;
        wr_cnt_d = (wr_cnt_q == '1) ? wr_cnt_q : wr_cnt_q + 1'b1;
      end
    end
  end

  slow_mem_array #(
    .LINE_W (LINE_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .idx   (addr_q[IDX_W-1:0]),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

  assign mem_rdata = rdata_q;
  assign oob_err   = oob_q;
  assign proto_err = proto_q;
  assign rd_cnt    = rd_cnt_q;
  assign wr_cnt    = wr_cnt_q;

endmodule

// File: tb/tb_slow_mem_ctrl.sv
// Scoreboard bench: a default-geometry controller plus a LATENCY=1, CNT_W=2 instance for saturation.
module tb_slow_mem_ctrl;

  localparam int LAT = 5;

  typedef struct {
    bit           is_rd;
    logic [127:0] rdata;
    int           exp_cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         mem_read = 1'b0, mem_write = 1'b0;
  logic [27:0]  mem_addr = '0;
  logic [127:0] mem_wdata = '0;
  logic [127:0] mem_rdata;
  logic         mem_ready, oob_err, proto_err;
  logic [15:0]  rd_cnt, wr_cnt;

  logic         rd1 = 1'b0, wr1 = 1'b0;
  logic [27:0]  addr1 = '0;
  logic [127:0] wdata1 = '0;
  logic [127:0] rdata1;
  logic         rdy1, oob1, proto1;
  logic [1:0]   rd_cnt1, wr_cnt1;

  int   n_chk = 0, n_fail = 0;
  int   cyc = 0, n_ready = 0, n1 = 0;
  int   exp_rd_n = 0, exp_wr_n = 0;
  logic prev_rdy = 1'b0, prev1 = 1'b0;
  logic [127:0] exp1 = '0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  slow_mem_ctrl #(.ADDR_W(28), .LINE_W(128), .DEPTH(256), .LATENCY(LAT), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .oob_err(oob_err),
    .proto_err(proto_err), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  slow_mem_ctrl #(.ADDR_W(28), .LINE_W(128), .DEPTH(16), .LATENCY(1), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst(rst), .mem_read(rd1), .mem_write(wr1), .mem_addr(addr1),
    .mem_wdata(wdata1), .mem_rdata(rdata1), .mem_ready(rdy1), .oob_err(oob1),
    .proto_err(proto1), .rd_cnt(rd_cnt1), .wr_cnt(wr_cnt1)
  );

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_ready === 1'b1) begin
      exp_t e;
      check("ready_width", prev_rdy, 1'b0);
      check("sb_nonempty", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("latency", cyc, e.exp_cyc);
        if (e.is_rd) check("rdata", mem_rdata, e.rdata);
      end
      n_ready++;
    end
    prev_rdy = mem_ready;
  end

  always @(negedge clk) begin
    if (rdy1 === 1'b1) begin
      check("d1_ready_width", prev1, 1'b0);
      if (rd1) check("d1_rdata", rdata1, exp1);
      n1++;
    end
    prev1 = rdy1;
  end

  // Issue one request on the main instance; exp_rd is the line a read must return.
  task automatic req(input bit rd, input bit wr, input logic [27:0] a, input logic [127:0] d,
                     input logic [127:0] exp_rd, input bit hold, input bit drop);
    exp_t e;
    int start;
    @(negedge clk);
    mem_read = rd; mem_write = wr; mem_addr = a; mem_wdata = d;
    e.is_rd = rd && !wr;
    e.rdata = exp_rd;
    e.exp_cyc = cyc + 1 + LAT;
    sb.push_back(e);
    if (wr) exp_wr_n++; else exp_rd_n++;
    start = n_ready;
    if (drop) begin
      @(negedge clk);
      mem_read = 1'b0; mem_write = 1'b0; mem_addr = '1; mem_wdata = '1;
    end
    for (int i = 0; i < 40 && n_ready == start; i++) @(posedge clk);
    check("req_done", n_ready - start, 1);
    if (!hold) begin
      @(negedge clk);
      mem_read = 1'b0; mem_write = 1'b0;
    end
  endtask

  task automatic wait1(input int n);
    int start;
    start = n1;
    for (int i = 0; i < 60 && (n1 - start) < n; i++) @(posedge clk);
    check("d1_done", n1 - start, n);
  endtask

  initial begin
    int start;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready", mem_ready, 1'b0);
    check("rst_rdata", mem_rdata, '0);
    check("rst_oob", oob_err, 1'b0);
    check("rst_proto", proto_err, 1'b0);
    check("rst_rd_cnt", rd_cnt, 16'd0);
    check("rst_wr_cnt", wr_cnt, 16'd0);

    req(0, 1, 28'd3, {16{8'hA5}}, '0, 0, 0);
    req(1, 0, 28'd3, '0, {16{8'hA5}}, 0, 0);
    check("cnt_rd_a", rd_cnt, 16'(exp_rd_n));
    check("cnt_wr_a", wr_cnt, 16'(exp_wr_n));

    // Held write: the request level seen during RECOVER must not start a second write.
    req(0, 1, 28'd7, 128'h1234, '0, 1, 0);
    req(1, 0, 28'd7, '0, 128'h1234, 0, 0);
    check("cnt_rd_b", rd_cnt, 16'(exp_rd_n));
    check("cnt_wr_b", wr_cnt, 16'(exp_wr_n));

    req(0, 1, 28'd44, 128'hBEEF, '0, 0, 0);
    check("oob_clear", oob_err, 1'b0);
    req(1, 0, 28'd300, '0, '0, 0, 0);
    check("oob_set_rd", oob_err, 1'b1);
    req(0, 1, 28'd300, 128'hDEAD, '0, 0, 0);
    req(1, 0, 28'd44, '0, 128'hBEEF, 0, 0);
    check("oob_sticky", oob_err, 1'b1);

    check("proto_clear", proto_err, 1'b0);
    req(1, 1, 28'd2, 128'hF, '0, 0, 0);
    check("proto_set", proto_err, 1'b1);
    req(1, 0, 28'd2, '0, 128'hF, 0, 0);
    check("proto_sticky", proto_err, 1'b1);

    req(1, 0, 28'd7, '0, 128'h1234, 0, 1);
    req(0, 1, 28'd5, 128'h55, '0, 0, 1);
    req(1, 0, 28'd5, '0, 128'h55, 0, 0);
    check("rdata_hold_wr", mem_rdata, 128'h55);
    req(0, 1, 28'd6, 128'h66, '0, 0, 0);
    check("rdata_after_wr", mem_rdata, 128'h55);
    check("cnt_rd_c", rd_cnt, 16'(exp_rd_n));
    check("cnt_wr_c", wr_cnt, 16'(exp_wr_n));

    req(0, 1, 28'd9, 128'h99, '0, 0, 0);
    @(negedge clk);
    mem_write = 1'b1; mem_addr = 28'd9; mem_wdata = 128'hBAD;
    start = n_ready;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; mem_write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_rd_n = 0; exp_wr_n = 0;
    repeat (10) @(negedge clk);
    check("abort_no_ready", n_ready - start, 0);
    check("abort_rd_cnt", rd_cnt, 16'd0);
    check("abort_wr_cnt", wr_cnt, 16'd0);
    check("abort_oob", oob_err, 1'b0);
    check("abort_proto", proto_err, 1'b0);
    check("abort_rdata", mem_rdata, '0);
    req(1, 0, 28'd9, '0, 128'h99, 0, 0);
    check("cnt_rd_d", rd_cnt, 16'(exp_rd_n));
    check("sb_drained", sb.size(), 0);

    @(negedge clk);
    wr1 = 1'b1; addr1 = 28'd0; wdata1 = {4{32'h1111_1111}};
    wait1(1);
    @(negedge clk);
    addr1 = 28'd1; wdata1 = {4{32'h2222_2222}};
    wait1(1);
    @(negedge clk);
    wr1 = 1'b0;
    check("d1_wr_cnt", wr_cnt1, 2'd2);
    check("d1_rd_cnt0", rd_cnt1, 2'd0);
    exp1 = {4{32'h1111_1111}};
    rd1 = 1'b1; addr1 = 28'd0;
    wait1(1);
    @(negedge clk);
    exp1 = {4{32'h2222_2222}};
    addr1 = 28'd1;
    wait1(5);
    @(negedge clk);
    rd1 = 1'b0;
    check("d1_rd_sat", rd_cnt1, 2'd3);
    check("d1_wr_hold", wr_cnt1, 2'd2);
    check("d1_rdata_last", rdata1, {4{32'h2222_2222}});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
